// File: rtl/qspi_pkg.sv
// qspi_pkg: shared opcode, output-enable patterns and state encoding for the quad-read flash master.
package qspi_pkg;
   localparam logic [7:0] QSPI_FAST_READ_QUAD = 8'h6B;
   localparam logic [3:0] IO_OE_IO0  = 4'b0001;
   localparam logic [3:0] IO_OE_NONE = 4'b0000;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GUARD} state_t;
endpackage

// File: rtl/qspi_sck_gen.sv
// qspi_sck_gen: SCK divider; tick strobes flag the mclk edge that starts a low phase (fall) or raises sck (rise).
module qspi_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic mclk,
   input  logic RESETn,
   input  logic run,
   input  logic pause,
   output logic sck,
   output logic fall_tick,
   output logic rise_tick
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int H  = CLK_DIV / 2;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d, en;
   // pause is only honoured at the very start of a low phase so a clock is never stretched
   always_comb begin
      en        = run && !(pause && cnt_q == '0);
      cnt_d     = !run ? '0 : !en ? cnt_q : (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
      sck_d     = cnt_d >= CW'(H);
      rise_tick = en && cnt_q == CW'(H - 1);
      fall_tick = en && cnt_q == CW'(CLK_DIV - 1);
   end
   always_ff @(posedge mclk or negedge RESETn)
      if (!RESETn) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   assign sck = sck_q;
endmodule

// File: rtl/qspi_read_engine.sv
// qspi_read_engine: quad-output fast-read (0x6B) SPI flash master returning a valid/ready byte stream.
module qspi_read_engine
   import qspi_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int DUMMY_CYCLES = 8,
   parameter int CS_HIGH_CYC  = 4
) (
   input  logic        mclk,
   input  logic        RESETn,
   input  logic        start,
   input  logic [23:0] addr,
   input  logic [15:0] len,
   output logic        busy,
   output logic        done,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sck,
   output logic        cs_n,
   output logic [3:0]  io_out,
   output logic [3:0]  io_oe,
   input  logic [3:0]  io_in
);
   localparam int H  = CLK_DIV / 2;
   localparam int GW = $clog2(H + CS_HIGH_CYC + 1);
   state_t          state_q, state_d;
   logic [30:0]     sh_q, sh_d;
   logic [5:0]      bit_q, bit_d;
   logic [15:0]     bytes_q, bytes_d;
   logic [3:0]      hi_q, hi_d, io_out_q, io_out_d, io_oe_q, io_oe_d;
   logic [GW-1:0]   g_q, g_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
   logic            run, pause, fall_tick, rise_tick;
   assign run   = state_q != IDLE && state_q != GUARD;
   assign pause = state_q == DATA && !bit_q[0] && out_valid_q && !out_ready;
   qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
      .mclk(mclk), .RESETn(RESETn), .run(run), .pause(pause),
      .sck(sck), .fall_tick(fall_tick), .rise_tick(rise_tick)
   );
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      bit_d       = bit_q;
      bytes_d     = bytes_q;
      hi_d        = hi_q;
      g_d         = g_q;
      cs_n_d      = cs_n_q;
      io_out_d    = io_out_q;
      io_oe_d     = io_oe_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !out_ready;
      case (state_q)
         IDLE: if (start) begin
            if (len == '0) done_d = 1'b1;
            else begin
               state_d  = CMD;
               sh_d     = {QSPI_FAST_READ_QUAD[6:0], addr};
               bytes_d  = len;
               bit_d    = '0;
               cs_n_d   = 1'b0;
               busy_d   = 1'b1;
               io_oe_d  = IO_OE_IO0;
               io_out_d = {3'b110, QSPI_FAST_READ_QUAD[7]};
            end
         end
         // opcode and address form one continuous MSB-first stream on IO0; WP/HOLD driven high
         CMD, ADDR: if (fall_tick) begin
            sh_d     = {sh_q[29:0], 1'b0};
            io_out_d = {3'b110, sh_q[30]};
            bit_d    = bit_q + 1'b1;
            if (state_q == CMD && bit_q == 6'd7) begin
               state_d = ADDR;
               bit_d   = '0;
            end
            if (state_q == ADDR && bit_q == 6'd23) begin
               state_d  = DUMMY;
               bit_d    = '0;
               io_out_d = '0;
               io_oe_d  = IO_OE_NONE;
            end
         end
         DUMMY: if (fall_tick) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == 6'(DUMMY_CYCLES - 1)) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (rise_tick) begin
               if (!bit_q[0]) hi_d = io_in;
               else begin
                  out_data_d  = {hi_q, io_in};
                  out_valid_d = 1'b1;
                  bytes_d     = bytes_q - 1'b1;
               end
            end
            if (fall_tick) begin
               bit_d = {5'b0, ~bit_q[0]};
               if (bit_q[0] && bytes_q == '0) begin
                  state_d = GUARD;
                  g_d     = '0;
               end
            end
         end
         // cs_n rises half an SCK period after the last fall, then stays high CS_HIGH_CYC cycles
         GUARD: begin
            g_d = (g_q == GW'(H + CS_HIGH_CYC - 1)) ? g_q : g_q + 1'b1;
            if (g_q == GW'(H - 1)) cs_n_d = 1'b1;
            if (g_q == GW'(H + CS_HIGH_CYC - 1) && !out_valid_d) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge mclk or negedge RESETn)
      if (!RESETn) begin
         state_q     <= IDLE;
         sh_q        <= '0;
         bit_q       <= '0;
         bytes_q     <= '0;
         hi_q        <= '0;
         g_q         <= '0;
         cs_n_q      <= 1'b1;
         io_out_q    <= '0;
         io_oe_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         bit_q       <= bit_d;
         bytes_q     <= bytes_d;
         hi_q        <= hi_d;
         g_q         <= g_d;
         cs_n_q      <= cs_n_d;
         io_out_q    <= io_out_d;
         io_oe_q     <= io_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   assign busy      = busy_q;
   assign done      = done_q;
   assign cs_n      = cs_n_q;
   assign io_out    = io_out_q;
   assign io_oe     = io_oe_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_qspi_read_engine.sv
// tb_qspi_read_engine: two engines (div 4 / dummy 8 and div 2 / dummy 6) against a behavioural quad flash model.
module tb_qspi_read_engine;
   logic        mclk = 1'b0, rst_n = 1'b0;
   logic [1:0]  start = 2'b00, out_ready = 2'b11, busy, done, out_valid, sck, cs_n;
   logic [23:0] addr [2];
   logic [15:0] len [2];
   logic [7:0]  out_data [2];
   logic [3:0]  io_out [2], io_oe [2], io_in [2];
   int          total = 0, bad = 0;
   int          nr [2] = '{0, 0}, viol [2] = '{0, 0}, nrx [2] = '{0, 0}, dn [2] = '{0, 0};
   int          cshi [2] = '{0, 0}, act [2] = '{0, 0}, lowrun [2] = '{0, 0}, maxlow [2] = '{0, 0}, cslow [2] = '{0, 0};
   logic [7:0]  op [2];
   logic [23:0] ad [2];
   logic [7:0]  rx [2][64];
   logic [1:0]  sck_p = 2'b00, cs_p = 2'b11;

   always #5 mclk = ~mclk;

   function automatic logic [7:0] mem(input logic [23:0] a);
      case (a)
         24'h001000: return 8'hA5;
         24'h001001: return 8'h3C;
         24'h001002: return 8'h00;
         24'h001003: return 8'hFF;
         default:    return a[7:0] ^ a[15:8] ^ ~a[23:16];
      endcase
   endfunction

   // flash presents the nibble for SCK clock n while that clock is low
   function automatic logic [3:0] flash_nib(input int n, input logic [23:0] a, input int dm);
      int j;
      logic [7:0] b;
      j = n - 32 - dm;
      b = mem(24'(a + 24'(j / 2)));
      return (j < 0) ? 4'h0 : (j % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      qspi_read_engine #(.CLK_DIV(g ? 2 : 4), .DUMMY_CYCLES(g ? 6 : 8), .CS_HIGH_CYC(4)) dut (
         .mclk(mclk), .RESETn(rst_n), .start(start[g]), .addr(addr[g]), .len(len[g]),
         .busy(busy[g]), .done(done[g]), .out_data(out_data[g]), .out_valid(out_valid[g]),
         .out_ready(out_ready[g]), .sck(sck[g]), .cs_n(cs_n[g]), .io_out(io_out[g]),
         .io_oe(io_oe[g]), .io_in(io_in[g])
      );
      assign io_in[g] = flash_nib(nr[g], ad[g], g ? 6 : 8);
   end

   always @(negedge mclk)
      for (int g = 0; g < 2; g++) begin
         if (!cs_n[g] && cs_p[g]) begin
            nr[g] <= 0; nrx[g] <= 0; viol[g] <= 0; cshi[g] <= 0;
            maxlow[g] <= 0; lowrun[g] <= 0; cslow[g] <= 1;
         end else begin
            if (!cs_n[g] && sck[g] && !sck_p[g]) begin
               if (nr[g] < 8) op[g] <= {op[g][6:0], io_out[g][0]};
               else if (nr[g] < 32) ad[g] <= {ad[g][22:0], io_out[g][0]};
               viol[g] <= viol[g] + int'(io_oe[g] !== (nr[g] < 32 ? 4'b0001 : 4'b0000))
                                  + int'(nr[g] < 8 && io_out[g][3:2] !== 2'b11);
               nr[g] <= nr[g] + 1;
            end
            lowrun[g] <= (!cs_n[g] && !sck[g]) ? lowrun[g] + 1 : 0;
            if (lowrun[g] > maxlow[g]) maxlow[g] <= lowrun[g];
            if (out_valid[g] && out_ready[g]) begin
               rx[g][nrx[g] % 64] <= out_data[g];
               nrx[g] <= nrx[g] + 1;
            end
            if (cs_n[g] && busy[g]) cshi[g] <= cshi[g] + 1;
            if (!cs_n[g]) cslow[g] <= cslow[g] + 1;
         end
         if (done[g]) dn[g] <= dn[g] + 1;
         if (!cs_n[g] || sck[g] || io_oe[g] != 4'b0000) act[g] <= act[g] + 1;
         sck_p[g] <= sck[g];
         cs_p[g]  <= cs_n[g];
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // mode 0: ready high, 1: 40-cycle stall after byte 1, 2: random ready, 3: restart attempt during ADDR
   task automatic run_xfer(input int g, input logic [23:0] a, input logic [15:0] l, input int mode, input string tag);
      int d0, cyc, st, dm, cd;
      bit rs;
      d0 = dn[g]; cyc = 0; st = 0; rs = 0;
      dm = g ? 6 : 8;
      cd = g ? 2 : 4;
      @(posedge mclk); #1;
      addr[g] = a; len[g] = l; start[g] = 1'b1; out_ready[g] = 1'b1;
      @(posedge mclk); #1;
      start[g] = 1'b0; addr[g] = 24'($urandom); len[g] = 16'($urandom);
      while (dn[g] == d0 && cyc < 20000) begin
         if (mode == 1) begin
            out_ready[g] = !(cyc > 4 && nrx[g] == 1 && st < 40);
            if (!out_ready[g]) st++;
         end
         if (mode == 2) out_ready[g] = ($urandom_range(0, 3) != 0);
         if (mode == 3) begin
            start[g] = (cyc > 4 && nr[g] == 12 && !rs);
            if (start[g]) begin
               rs = 1; addr[g] = 24'hFFFFFF; len[g] = 16'd9;
            end
         end
         @(posedge mclk); #1;
         cyc++;
      end
      start[g] = 1'b0; out_ready[g] = 1'b1;
      chk({tag, ".no_timeout"}, 32'(cyc < 20000), 1);
      repeat (10) @(posedge mclk);
      #1;
      chk({tag, ".opcode"}, 32'(op[g]), 32'h6B);
      chk({tag, ".addr"}, 32'(ad[g]), 32'(a));
      chk({tag, ".sck_rises"}, nr[g], 32 + dm + 2 * int'(l));
      chk({tag, ".nbytes"}, nrx[g], int'(l));
      for (int i = 0; i < int'(l) && i < 64; i++)
         chk($sformatf("%s.byte%0d", tag, i), 32'(rx[g][i]), 32'(mem(24'(a + 24'(i)))));
      chk({tag, ".done_pulses"}, dn[g] - d0, 1);
      chk({tag, ".pin_dirs"}, viol[g], 0);
      chk({tag, ".cs_guard_ok"}, 32'(cshi[g] >= 4), 1);
      chk({tag, ".idle_pins"}, {busy[g], cs_n[g], sck[g], out_valid[g], io_oe[g]}, 8'b0100_0000);
      if (mode == 0 || mode == 3) chk({tag, ".cs_low_cycles"}, cslow[g], (32 + dm + 2 * int'(l)) * cd + cd / 2);
      if (mode == 1) chk({tag, ".stall_sck_low"}, 32'(maxlow[g] > 20), 1);
   endtask

   initial begin
      int a0, d0, cyc;
      addr[0] = '0; addr[1] = '0; len[0] = '0; len[1] = '0;
      repeat (3) @(posedge mclk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("reset%0d.ctrl", g), {cs_n[g], sck[g], busy[g], done[g], out_valid[g]}, 5'b10000);
         chk($sformatf("reset%0d.io", g), {io_oe[g], io_out[g], out_data[g]}, 16'h0000);
      end
      @(negedge mclk);
      rst_n = 1'b1;

      run_xfer(0, 24'h001000, 16'd4, 0, "basic");

      a0 = act[0]; d0 = dn[0];
      @(posedge mclk); #1;
      addr[0] = 24'h123456; len[0] = 16'd0; start[0] = 1'b1;
      @(posedge mclk); #1;
      start[0] = 1'b0;
      @(negedge mclk);
      chk("len0.done_busy", {done[0], busy[0]}, 2'b10);
      @(negedge mclk);
      chk("len0.single_pulse", done[0], 1'b0);
      repeat (5) @(posedge mclk);
      #1;
      chk("len0.no_pins", act[0] - a0, 0);
      chk("len0.done_count", dn[0] - d0, 1);

      run_xfer(0, 24'h001000, 16'd4, 1, "stall");
      run_xfer(0, 24'h001000, 16'd4, 3, "restart");

      @(posedge mclk); #1;
      addr[0] = 24'h001000; len[0] = 16'd4; start[0] = 1'b1; out_ready[0] = 1'b1;
      @(posedge mclk); #1;
      start[0] = 1'b0;
      repeat (2) @(posedge mclk);
      #1;
      cyc = 0;
      while (nrx[0] < 1 && cyc < 2000) begin
         @(posedge mclk); #1;
         cyc++;
      end
      chk("rst.reached_byte2", 32'(cyc < 2000), 1);
      repeat (3) @(posedge mclk);
      #1;
      chk("rst.active_before", cs_n[0], 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst.async_pins", {cs_n[0], sck[0], busy[0], out_valid[0], io_oe[0]}, 8'b1000_0000);
      @(negedge mclk);
      rst_n = 1'b1;
      run_xfer(0, 24'($urandom), 16'd1, 0, "post_rst");

      run_xfer(1, 24'h001000, 16'd2, 0, "div2");
      run_xfer(1, 24'($urandom), 16'($urandom_range(1, 5)), 2, "div2_rnd");
      run_xfer(0, 24'hFFFFFE, 16'd4, 0, "wrap");
      for (int k = 0; k < 4; k++)
         run_xfer(0, 24'($urandom), 16'($urandom_range(1, 6)), 2, $sformatf("rnd%0d", k));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
